// File: rtl/hamster_motor_pkg.sv
// rtl/hamster_motor_pkg.sv - shared types and quadrature decode for the motor path
package hamster_motor_pkg;

    typedef enum logic [1:0] {
        DISABLED   = 2'd0,
        WAIT_INDEX = 2'd1,
        LOCKED     = 2'd2
    } abi_state_e;

    typedef enum logic [1:0] {
        QUAD_NONE    = 2'd0,
        QUAD_FWD     = 2'd1,
        QUAD_REV     = 2'd2,
        QUAD_ILLEGAL = 2'd3
    } quad_evt_e;

    // AB packed as {a, b}; forward (A leads) runs 00 -> 10 -> 11 -> 01 -> 00
    function automatic quad_evt_e quad_decode(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] fwd_next;
        case (prev)
            2'b00:   fwd_next = 2'b10;
            2'b10:   fwd_next = 2'b11;
            2'b11:   fwd_next = 2'b01;
            default: fwd_next = 2'b00;
        endcase
        if (cur == prev)
            return QUAD_NONE;
        else if (cur == fwd_next)
            return QUAD_FWD;
        else if (cur == ~prev)
            return QUAD_ILLEGAL;
        else
            return QUAD_REV;
    endfunction

endpackage

// File: rtl/abi_glitch_filter.sv
// rtl/abi_glitch_filter.sv - 2-FF synchroniser plus stable-count glitch filter for one pin
module abi_glitch_filter #(
    parameter int K_FILT_W = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_pin,
    input  logic [K_FILT_W-1:0] i_filter_len,
    output logic                o_filt
);

    logic                sync1;
    logic                sync2;
    logic [K_FILT_W-1:0] cnt;

    // cnt counts cycles of disagreement already seen; the (filter_len+1)th one commits
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            cnt    <= '0;
            o_filt <= 1'b0;
        end else begin
            sync1 <= i_pin;
            sync2 <= sync1;
            if (sync2 != o_filt) begin
                if (cnt >= i_filter_len) begin
                    o_filt <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/abi_encoder_frontend.sv
// rtl/abi_encoder_frontend.sv - quadrature A/B/I front end producing step and force-step pulses
module abi_encoder_frontend
    import hamster_motor_pkg::*;
#(
    parameter int K_NSUBSTEPS = 10,
    parameter int K_CPR       = 1024,
    parameter int K_FILT_W    = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_enc_a,
    input  logic                           i_enc_b,
    input  logic                           i_enc_i,
    input  logic                           i_enable,
    input  logic [K_FILT_W-1:0]            i_filter_len,
    input  logic                           i_dir_invert,
    input  logic [2:0]                     i_index_step,
    input  logic [$clog2(K_NSUBSTEPS)-1:0] i_index_substep,
    input  logic                           i_clear_error,
    output logic                           o_step_trigger,
    output logic                           o_step_dir,
    output logic                           o_force_step_trigger,
    output logic [2:0]                     o_force_step_value,
    output logic [$clog2(K_NSUBSTEPS)-1:0] o_force_substep,
    output logic [$clog2(K_CPR)-1:0]       o_position,
    output logic                           o_locked,
    output logic                           o_err_quad,
    output logic                           o_err_index
);

    localparam int SUB_W = $clog2(K_NSUBSTEPS);
    localparam int POS_W = $clog2(K_CPR);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(K_CPR - 1);

    logic       f_a, f_b, f_i;
    logic [1:0] ab_q;
    logic       i_q;

    abi_state_e state, next_state;
    quad_evt_e  evt;
    logic       active, idx_ev;

    logic             step_d, dir_d, force_d, locked_d, err_quad_d, err_index_d;
    logic             set_quad, set_index;
    logic [2:0]       fval_d;
    logic [SUB_W-1:0] fsub_d;
    logic [POS_W-1:0] pos_d;

    abi_glitch_filter #(.K_FILT_W(K_FILT_W)) u_filt_a (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(i_enc_a), .i_filter_len(i_filter_len), .o_filt(f_a)
    );
    abi_glitch_filter #(.K_FILT_W(K_FILT_W)) u_filt_b (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(i_enc_b), .i_filter_len(i_filter_len), .o_filt(f_b)
    );
    abi_glitch_filter #(.K_FILT_W(K_FILT_W)) u_filt_i (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(i_enc_i), .i_filter_len(i_filter_len), .o_filt(f_i)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= DISABLED;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            DISABLED:   if (i_enable) next_state = WAIT_INDEX;
            WAIT_INDEX: if (idx_ev)   next_state = LOCKED;
            LOCKED:     next_state = LOCKED;
            default:    next_state = DISABLED;
        endcase
        if (!i_enable)
            next_state = DISABLED;
    end

    // Gating on i_enable as well as state keeps the cycle in which enable drops pulse-free
    assign active = i_enable && (state != DISABLED);
    assign idx_ev = active && f_i && !i_q;
    assign evt    = quad_decode(ab_q, {f_a, f_b});

    always_comb begin
        step_d    = 1'b0;
        dir_d     = o_step_dir;
        force_d   = 1'b0;
        fval_d    = o_force_step_value;
        fsub_d    = o_force_substep;
        pos_d     = o_position;
        set_quad  = active && (evt == QUAD_ILLEGAL);
        set_index = 1'b0;
        if (idx_ev) begin
            force_d   = 1'b1;
            fval_d    = i_index_step;
            fsub_d    = i_index_substep;
            pos_d     = '0;
            set_index = (state == LOCKED) && (o_position != '0);
        end else if (active && (evt == QUAD_FWD || evt == QUAD_REV)) begin
            step_d = 1'b1;
            dir_d  = (evt == QUAD_FWD) ^ i_dir_invert;
            if (dir_d)
                pos_d = (o_position == POS_MAX) ? '0 : o_position + 1'b1;
            else
                pos_d = (o_position == '0) ? POS_MAX : o_position - 1'b1;
        end
        locked_d    = (next_state == LOCKED);
        err_quad_d  = set_quad  || (o_err_quad  && !i_clear_error);
        err_index_d = set_index || (o_err_index && !i_clear_error);
    end

    // ab_q and i_q follow the filters in every state so enabling never sees a stale edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ab_q                 <= 2'b00;
            i_q                  <= 1'b0;
            o_step_trigger       <= 1'b0;
            o_step_dir           <= 1'b0;
            o_force_step_trigger <= 1'b0;
            o_force_step_value   <= '0;
            o_force_substep      <= '0;
            o_position           <= '0;
            o_locked             <= 1'b0;
            o_err_quad           <= 1'b0;
            o_err_index          <= 1'b0;
        end else begin
            ab_q                 <= {f_a, f_b};
            i_q                  <= f_i;
            o_step_trigger       <= step_d;
            o_step_dir           <= dir_d;
            o_force_step_trigger <= force_d;
            o_force_step_value   <= fval_d;
            o_force_substep      <= fsub_d;
            o_position           <= pos_d;
            o_locked             <= locked_d;
            o_err_quad           <= err_quad_d;
            o_err_index          <= err_index_d;
        end
    end

endmodule

// File: tb/tb_abi_encoder_frontend.sv
// tb/tb_abi_encoder_frontend.sv - directed self-checking bench for abi_encoder_frontend
module tb_abi_encoder_frontend;

    localparam int CPR = 1024;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_enc_a, i_enc_b, i_enc_i;
    logic       i_enable;
    logic [3:0] i_filter_len;
    logic       i_dir_invert;
    logic [2:0] i_index_step;
    logic [3:0] i_index_substep;
    logic       i_clear_error;
    logic       o_step_trigger, o_step_dir, o_force_step_trigger;
    logic [2:0] o_force_step_value;
    logic [3:0] o_force_substep;
    logic [9:0] o_position;
    logic       o_locked, o_err_quad, o_err_index;

    int n_checks = 0;
    int n_errors = 0;
    logic [1:0] ab_cur;
    int exp_pos;

    abi_encoder_frontend #(.K_NSUBSTEPS(10), .K_CPR(CPR), .K_FILT_W(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_enc_a(i_enc_a), .i_enc_b(i_enc_b), .i_enc_i(i_enc_i),
        .i_enable(i_enable), .i_filter_len(i_filter_len), .i_dir_invert(i_dir_invert),
        .i_index_step(i_index_step), .i_index_substep(i_index_substep),
        .i_clear_error(i_clear_error),
        .o_step_trigger(o_step_trigger), .o_step_dir(o_step_dir),
        .o_force_step_trigger(o_force_step_trigger), .o_force_step_value(o_force_step_value),
        .o_force_substep(o_force_substep), .o_position(o_position), .o_locked(o_locked),
        .o_err_quad(o_err_quad), .o_err_index(o_err_index)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [1:0] ab;
        logic       inv;
        logic       exp_dir;
        int         exp_pos;
    } vec_t;

    vec_t vecs[20];

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [1:0] fwd_of(input logic [1:0] x);
        case (x)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic apply_ab(input logic [1:0] ab);
        ab_cur  = ab;
        i_enc_a = ab[1];
        i_enc_b = ab[0];
    endtask

    task automatic step_fwd(input int n, input bit expect_step, input string name);
        int trigs;
        for (int k = 0; k < n; k++) begin
            apply_ab(fwd_of(ab_cur));
            if (expect_step) exp_pos = (exp_pos + 1) % CPR;
            trigs = 0;
            repeat (6) begin
                tick();
                trigs += int'(o_step_trigger);
            end
            check({name, " trig"}, trigs, expect_step ? 1 : 0);
        end
        check({name, " pos"}, int'(o_position), exp_pos);
    endtask

    task automatic count_pulses(input int n, output int trigs, output int forces);
        trigs = 0;
        forces = 0;
        repeat (n) begin
            tick();
            trigs  += int'(o_step_trigger);
            forces += int'(o_force_step_trigger);
        end
    endtask

    initial begin
        int trigs, forces, first, cap_val, cap_sub, cap_pos, cap_lock, cap_erri;

        vecs[0]  = '{2'b10, 1'b0, 1'b1, 1};
        vecs[1]  = '{2'b11, 1'b0, 1'b1, 2};
        vecs[2]  = '{2'b01, 1'b0, 1'b1, 3};
        vecs[3]  = '{2'b00, 1'b0, 1'b1, 4};
        vecs[4]  = '{2'b10, 1'b0, 1'b1, 5};
        vecs[5]  = '{2'b11, 1'b0, 1'b1, 6};
        vecs[6]  = '{2'b01, 1'b0, 1'b1, 7};
        vecs[7]  = '{2'b00, 1'b0, 1'b1, 8};
        vecs[8]  = '{2'b01, 1'b0, 1'b0, 7};
        vecs[9]  = '{2'b11, 1'b0, 1'b0, 6};
        vecs[10] = '{2'b10, 1'b0, 1'b0, 5};
        vecs[11] = '{2'b00, 1'b0, 1'b0, 4};
        vecs[12] = '{2'b01, 1'b0, 1'b0, 3};
        vecs[13] = '{2'b11, 1'b0, 1'b0, 2};
        vecs[14] = '{2'b10, 1'b0, 1'b0, 1};
        vecs[15] = '{2'b00, 1'b0, 1'b0, 0};
        vecs[16] = '{2'b01, 1'b0, 1'b0, 1023};
        vecs[17] = '{2'b11, 1'b0, 1'b0, 1022};
        vecs[18] = '{2'b10, 1'b0, 1'b0, 1021};
        vecs[19] = '{2'b00, 1'b1, 1'b1, 1022};

        i_rst_n = 1'b0;
        i_enc_a = 1'b0; i_enc_b = 1'b0; i_enc_i = 1'b0;
        i_enable = 1'b0; i_filter_len = 4'd0; i_dir_invert = 1'b0;
        i_index_step = 3'd0; i_index_substep = 4'd0; i_clear_error = 1'b0;
        ab_cur = 2'b00;
        exp_pos = 0;
        tick();
        tick();
        check("reset trig", int'(o_step_trigger), 0);
        check("reset force", int'(o_force_step_trigger), 0);
        check("reset pos", int'(o_position), 0);
        check("reset locked", int'(o_locked), 0);
        check("reset errs", int'({o_err_quad, o_err_index}), 0);
        i_rst_n = 1'b1;
        tick();
        check("first cycle trig", int'(o_step_trigger), 0);
        i_enable = 1'b1;
        repeat (4) tick();

        // table: forward run, reverse run through the 0 wrap, then inverted sense
        for (int v = 0; v < 20; v++) begin
            apply_ab(vecs[v].ab);
            i_dir_invert = vecs[v].inv;
            repeat (3) tick();
            check($sformatf("vec%0d early", v), int'(o_step_trigger), 0);
            tick();
            check($sformatf("vec%0d trig", v), int'(o_step_trigger), 1);
            check($sformatf("vec%0d dir", v), int'(o_step_dir), int'(vecs[v].exp_dir));
            check($sformatf("vec%0d pos", v), int'(o_position), vecs[v].exp_pos);
            tick();
            check($sformatf("vec%0d width", v), int'(o_step_trigger), 0);
            tick();
        end
        i_dir_invert = 1'b0;
        exp_pos = 1022;

        // glitch rejection with L=3
        i_filter_len = 4'd3;
        i_enc_a = 1'b1;
        repeat (3) tick();
        i_enc_a = 1'b0;
        count_pulses(12, trigs, forces);
        check("glitch3 trigs", trigs, 0);
        check("glitch3 pos", int'(o_position), 1022);
        i_enc_a = 1'b1;
        first = -1;
        trigs = 0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (t == 5) i_enc_a = 1'b0;
            if (o_step_trigger) begin
                trigs++;
                if (first < 0) first = t;
            end
        end
        check("glitch5 first", first, 7);
        check("glitch5 trigs", trigs, 2);
        check("glitch5 pos", int'(o_position), 1022);
        i_filter_len = 4'd0;

        step_fwd(7, 1'b1, "to5");
        check("locked pre-index", int'(o_locked), 0);

        // index alignment in WAIT_INDEX
        i_index_step = 3'd4;
        i_index_substep = 4'd7;
        i_enc_i = 1'b1;
        forces = 0; first = -1;
        cap_val = -1; cap_sub = -1; cap_pos = -1; cap_lock = -1; cap_erri = -1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (o_force_step_trigger) begin
                forces++;
                if (first < 0) begin
                    first = t;
                    cap_val = int'(o_force_step_value);
                    cap_sub = int'(o_force_substep);
                    cap_pos = int'(o_position);
                    cap_lock = int'(o_locked);
                    cap_erri = int'(o_err_index);
                end
            end
        end
        check("idx1 pulses", forces, 1);
        check("idx1 latency", first, 4);
        check("idx1 value", cap_val, 4);
        check("idx1 substep", cap_sub, 7);
        check("idx1 pos", cap_pos, 0);
        check("idx1 locked", cap_lock, 1);
        check("idx1 err", cap_erri, 0);
        i_index_step = 3'd2;
        i_enc_i = 1'b0;
        repeat (6) tick();
        check("force value hold", int'(o_force_step_value), 4);
        exp_pos = 0;

        // second index away from 0 while locked
        step_fwd(12, 1'b1, "to12");
        i_enc_i = 1'b1;
        repeat (4) tick();
        check("idx2 force", int'(o_force_step_trigger), 1);
        check("idx2 err", int'(o_err_index), 1);
        check("idx2 pos", int'(o_position), 0);
        i_enc_i = 1'b0;
        i_clear_error = 1'b1;
        tick();
        i_clear_error = 1'b0;
        check("idx err clear", int'(o_err_index), 0);
        repeat (4) tick();
        exp_pos = 0;

        // index and A edge filtered in the same cycle
        step_fwd(3, 1'b1, "to3");
        i_enc_i = 1'b1;
        apply_ab(fwd_of(ab_cur));
        repeat (4) tick();
        check("simul force", int'(o_force_step_trigger), 1);
        check("simul trig", int'(o_step_trigger), 0);
        check("simul pos", int'(o_position), 0);
        count_pulses(6, trigs, forces);
        check("simul late trig", trigs, 0);
        i_enc_i = 1'b0;
        i_clear_error = 1'b1;
        tick();
        i_clear_error = 1'b0;
        repeat (4) tick();
        exp_pos = 0;

        // both A and B toggled together
        apply_ab(~ab_cur);
        count_pulses(8, trigs, forces);
        check("quad trigs", trigs, 0);
        check("quad err", int'(o_err_quad), 1);
        check("quad pos", int'(o_position), 0);
        i_clear_error = 1'b1;
        tick();
        i_clear_error = 1'b0;
        check("quad clear", int'(o_err_quad), 0);

        // disable during motion, re-enable with AB != 00
        i_enable = 1'b0;
        step_fwd(2, 1'b0, "disabled");
        if (ab_cur == 2'b00) step_fwd(1, 1'b0, "disabled extra");
        check("disabled locked", int'(o_locked), 0);
        i_enable = 1'b1;
        count_pulses(8, trigs, forces);
        check("reenable spurious", trigs + forces, 0);
        check("reenable locked", int'(o_locked), 0);
        step_fwd(1, 1'b1, "after reenable");

        // reset mid-sequence
        step_fwd(1, 1'b1, "pre reset");
        apply_ab(fwd_of(ab_cur));
        repeat (2) tick();
        i_rst_n = 1'b0;
        #1;
        check("midrst pos", int'(o_position), 0);
        check("midrst dir", int'(o_step_dir), 0);
        check("midrst force val", int'(o_force_step_value), 0);
        check("midrst flags", int'({o_step_trigger, o_force_step_trigger, o_locked, o_err_quad, o_err_index}), 0);
        tick();
        tick();
        i_rst_n = 1'b1;
        count_pulses(8, trigs, forces);
        check("post reset pulses", trigs + forces, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
